mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the processor data-memory write bus (MemWrite, DataAdr, WriteData); consumes the stores the core produces.
- Stores to its DATA address push bytes into a small FIFO; a framing FSM serialises them onto tx as 8N1.
- Also drives a combinational STATUS word so firmware can poll before storing.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 58 +++++
 rtl/mmio_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package uart_pkg;

  // Framing FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Register offsets from the block base address.
  localparam logic [31:0] DATA_OFS   = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  // STATUS word bit positions.
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  // The STATUS count field is 4 bits wide; larger occupancies read as 15.
  function automatic logic [3:0] sat_count(input logic [31:0] c);
    return (c > 32'd15) ? 4'd15 : c[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout shows the head entry.
// Latency: a pushed entry is visible on dout/empty one cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  // When full, a simultaneous pop frees the slot the push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter fed by core stores, with a pollable STATUS word.
// Latency: store at edge k pops at edge k+1, start bit on tx from k+1; frame is 10*CLKS_PER_BIT cycles.
// Backpressure: none on the bus; stores to a full FIFO are dropped and flag sticky overflow.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0200,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        busy
);

  localparam int                CNT_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam int                FCW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0]       DATA_ADDR   = BASE_ADDR + DATA_OFS;
  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + STATUS_OFS;

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q;

  logic             push_req;
  logic             clear_req;
  logic             pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic             last_clk;
  logic [31:0]      status;
  logic [23:0]      unused_wdata;

  assign push_req     = MemWrite && (DataAdr == DATA_ADDR);
  assign clear_req    = MemWrite && (DataAdr == STATUS_ADDR) && WriteData[3];
  assign last_clk     = (cnt_q == CNT_LAST);
  assign unused_wdata = WriteData[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Framing next-state: bit timing, byte pops, and the next registered tx level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end
      end
      START: begin
        if (last_clk) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (last_clk) begin
          cnt_d = '0;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (last_clk) begin
          cnt_d = '0;
          // Chain straight into the next start bit so queued bytes leave gap-free.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is derived from the next state so the line changes on the same edge as the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // Framing state, counters, shift register and the tx flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Sticky overflow: a fresh drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      ovf_q <= 1'b1;
    end else if (clear_req) begin
      ovf_q <= 1'b0;
    end
  end

  // STATUS word assembly; reading it has no side effects.
  always_comb begin
    status                      = '0;
    status[ST_FULL]             = fifo_full;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_BUSY]             = (state_q != IDLE);
    status[ST_OVF]              = ovf_q;
    status[ST_CNT_LSB +: 4]     = sat_count(32'(fifo_count));
  end

  assign ReadData = (DataAdr == STATUS_ADDR) ? status : 32'd0;
  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with a frame-decoding monitor and byte scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mmio_uart_tx;

  localparam int          CPB  = 4;
  localparam logic [31:0] BASE = 32'h0000_0200;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        MemWrite  = 1'b0;
  logic [31:0] DataAdr   = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        tx;
  logic        busy;

  int          cyc         = 0;
  int          errors      = 0;
  int          checks      = 0;
  int          frames_done = 0;
  logic [7:0]  exp_q[$];
  int          start_q[$];

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycle stamp used to measure frame spacing and latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One store cycle; caller sits just after a rising edge, returns just after the next.
  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = addr;
    WriteData = data;
    @(posedge clk); #1;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  task automatic rd_status(output logic [31:0] v);
    DataAdr = BASE + 32'd4;
    #1;
    v = ReadData;
    DataAdr = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Frame monitor: decodes 8N1 on tx at falling edges, abandons a frame on reset.
  initial begin : monitor
    logic [7:0] b;
    int         st;
    bit         ab;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        st = cyc;
        b  = '0;
        ab = 1'b0;
        for (int p = 1; p <= 9*CPB + 1; p++) begin
          @(negedge clk);
          if (reset !== 1'b1) begin
            ab = 1'b1;
            break;
          end
          if (p == 1)
            check("start_bit", {31'd0, tx}, 32'd0);
          else if (p == 9*CPB + 1)
            check("stop_bit", {31'd0, tx}, 32'd1);
          else if (p > CPB && ((p - 1) % CPB) == 0)
            b[((p - 1) / CPB) - 1] = tx;
        end
        if (!ab) begin
          frames_done++;
          start_q.push_back(st);
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_frame: observed byte %h, expected no frame", b);
          end
          if (exp_q.size() != 0) check("frame_data", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] v;
    int          n;
    int          push_cyc;
    int          base_frames;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rd_status(v);
    check("rst_status", v, 32'h0000_0002);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    rd_status(v);
    check("post_rst_status", v, 32'h0000_0002);

    // Single byte 0x55.
    start_q.delete();
    exp_q.push_back(8'h55);
    bus_wr(BASE, 32'h0000_0055);
    push_cyc = cyc;
    rd_status(v);
    check("status_queued", v, 32'h0000_0010);
    check("busy_queued", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("tx_start_k1", {31'd0, tx}, 32'd0);
    rd_status(v);
    check("status_sending", v, 32'h0000_0006);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_len", n, 40);
    repeat (3) @(posedge clk);
    #1;
    check("single_frames", start_q.size(), 1);
    if (start_q.size() > 0) check("single_latency", start_q[0] - push_cyc, 1);

    // Back-to-back stores: two contiguous frames.
    start_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    bus_wr(BASE, 32'h0000_00A5);
    bus_wr(BASE, 32'h0000_003C);
    wait_idle("b2b_idle");
    check("b2b_frames", start_q.size(), 2);
    if (start_q.size() == 2) check("b2b_gap", start_q[1] - start_q[0], 10*CPB);

    // Overflow: six consecutive stores, the sixth is dropped.
    start_q.delete();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_q.push_back(8'(i));
      bus_wr(BASE, 32'(i));
    end
    rd_status(v);
    check("ovf_status", v, 32'h0000_004D);
    bus_wr(BASE + 32'd4, 32'h0000_0007);
    rd_status(v);
    check("ovf_no_clear_bit3_0", v, 32'h0000_004D);
    bus_wr(BASE + 32'd4, 32'h0000_0008);
    rd_status(v);
    check("ovf_cleared", v, 32'h0000_0045);
    wait_idle("ovf_idle");
    check("ovf_frames", start_q.size(), 5);
    check("ovf_sb_drained", exp_q.size(), 0);
    rd_status(v);
    check("ovf_end_status", v, 32'h0000_0002);

    // Foreign addresses are ignored.
    bus_wr(32'd100, 32'd7);
    bus_wr(32'd96, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    check("foreign_tx", {31'd0, tx}, 32'd1);
    check("foreign_busy", {31'd0, busy}, 32'd0);
    rd_status(v);
    check("foreign_status", v, 32'h0000_0002);
    DataAdr = 32'd100;
    #1;
    check("foreign_readdata", ReadData, 32'd0);
    DataAdr = '0;

    // Reset during bit 3 of 0x55 with 0x66 queued behind it.
    @(posedge clk); #1;
    base_frames = frames_done;
    bus_wr(BASE, 32'h0000_0055);
    bus_wr(BASE, 32'h0000_0066);
    repeat (17) @(posedge clk);
    #1;
    check("mid_bit3_low", {31'd0, tx}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    rd_status(v);
    check("mid_rst_status", v, 32'h0000_0002);
    repeat (60) @(posedge clk);
    #1;
    check("mid_rst_no_frame", frames_done, base_frames);
    check("mid_rst_tx_idle", {31'd0, tx}, 32'd1);
    check("final_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
